inst_fetch_buffer: RTL and testbench
====================================

Name: inst_fetch_buffer

Overview:
Line-buffered instruction-fetch bridge between the core's single-cycle ROM port and a variable-latency instruction memory that uses a req/ack handshake.
- Holds one aligned line of LINE_WORDS instructions.
- On a hit, it returns the instruction in the same cycle.
- On a miss, it asserts a stall request, burst-fills the line one word per ack, then serves the hit.
- Upstream of the core's IF/ID register; feeds rom_data_i and consumes rom_addr_o/rom_ce_o.

Parameters:
LINE_WORDS, 4, words per line; power of two, >=2
OFF_W, log2(LINE_WORDS) = 2, word-offset width; derived, not overridden

Ports:
clk  input  1  single clock, all state on rising edge
rst  input  1  reset, asynchronous, active-high
rom_ce_i  input  1  core fetch enable
rom_addr_i  input  32  core byte address; bits [1:0] ignored
rom_data_o  output  32  instruction to core
stallreq_o  output  1  fetch stall request to core pipeline control
mem_req_o  output  1  memory read request
mem_addr_o  output  32  memory byte address, word-aligned
mem_ack_i  input  1  memory read data valid this cycle
mem_rdata_i  input  32  memory read data, sampled only when mem_ack_i=1

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; line_valid=0; line_tag=0; fill_cnt=0; line data cleared to ZeroWord.
  - rom_data_o=0, stallreq_o=0, mem_req_o=0, mem_addr_o=0.
- Fields:
  - tag = rom_addr_i[31:2+OFF_W]
  - off = rom_addr_i[1+OFF_W:2]
- hit = rom_ce_i & line_valid & (tag==line_tag) & (state==IDLE).
- Outputs are combinational from state and inputs:
  - rom_ce_i=0: rom_data_o=0, stallreq_o=0; no fill starts.
  - hit: rom_data_o=line[off], stallreq_o=0, zero latency.
  - Otherwise, with rom_ce_i=1: rom_data_o=0 (NOP), stallreq_o=1.
- FSM IDLE:
  - On a miss with rom_ce_i=1: latch fill_tag=tag, fill_cnt=0, line_valid=0, go FILL.
  - Otherwise stay in IDLE.
- FSM FILL:
  - mem_req_o=1; mem_addr_o={fill_tag, fill_cnt, 2'b00}.
  - Request and address are held stable until ack.
  - On mem_ack_i=1: line[fill_cnt]=mem_rdata_i, fill_cnt++.
  - On the ack with fill_cnt==LINE_WORDS-1: line_tag=fill_tag, line_valid=1, fill_cnt=0, go IDLE.
  - mem_ack_i=0 leaves all state unchanged (unbounded wait).
  - stallreq_o=1 throughout FILL regardless of rom_addr_i.
- Latency:
  - Miss detected in cycle 0; req words in cycles 1..LINE_WORDS when ack is immediate.
  - Hit in cycle LINE_WORDS+1. Minimum stall is LINE_WORDS+1 cycles.
- Boundary cases:
  - Fill order is always word 0..LINE_WORDS-1 of the line (no critical-word-first).
  - If rom_addr_i changes during FILL (redirect), the fill completes for the latched fill_tag. The new address is evaluated in IDLE and may trigger a second fill.
  - rom_ce_i dropping during FILL: the fill still completes.
  - mem_ack_i while in IDLE is ignored.
  - Reset mid-FILL: line invalid, mem_req_o drops immediately (async).
  - Address 0xFFFF_FFFC: tag is all ones, offset is LINE_WORDS-1; the fill counter does not wrap into the tag.
  - Offset counter wrap: fill_cnt returns to 0 after the last word.

Decomposition:
- Shared define include:
  - InstAddressBus, InstDataBus, ZeroWord (already present).
  - New: FetchIdle/FetchFill state encodings (1 bit), a default for LINE_WORDS, and a NopInst (=ZeroWord) constant.
- One sub-module is natural: fetch_line_store, a LINE_WORDS x 32 register array with write port (we, waddr, wdata), async clear, and a combinational read port.
- FSM, tag compare, and memory handshake stay in inst_fetch_buffer.

Test Plan:
1. Reset, then rom_ce_i=1, rom_addr_i=0x0000_0000, ack immediate with rdata 0x3401_0020/0x3402_0030/0x3403_0040/0x3404_0050:
   - stallreq_o=1 for 5 cycles.
   - mem_addr_o sequence 0x0,0x4,0x8,0xC.
   - Then rom_data_o=0x3401_0020 with stallreq_o=0.
2. After scenario 1, step rom_addr_i 0x4,0x8,0xC:
   - rom_data_o returns 0x3402_0030, 0x3403_0040, 0x3404_0050 in consecutive cycles.
   - stallreq_o=0 and mem_req_o=0 throughout.
3. rom_addr_i=0x10 (miss), with mem_ack_i held low 3 cycles per word:
   - mem_addr_o holds 0x10 for 4 cycles, then 0x14, and so on.
   - The line becomes valid only after the fourth ack; the total stall is 17 cycles.
4. During a fill of 0x20, change rom_addr_i to 0x40 after the second ack:
   - The fill completes with addresses 0x28 and 0x2C.
   - IDLE then misses on 0x40 and starts a fill at mem_addr_o=0x40.
5. Assert rst asynchronously mid-fill (between edges):
   - mem_req_o, stallreq_o, and rom_data_o go to 0 immediately.
   - After release, re-reading the previously buffered address 0x0 misses and refills.
6. rom_ce_i=0 with any address:
   - rom_data_o=0, stallreq_o=0, mem_req_o=0.
   - No state change, and the line stays valid.

Source files
------------

// File: rtl/inst_fetch_buffer_pkg.sv
// rtl/inst_fetch_buffer_pkg.sv - shared widths, constants and FSM encodings for the fetch buffer
package inst_fetch_buffer_pkg;

    localparam int InstAddrWidth = 32;
    localparam int InstDataWidth = 32;

    typedef logic [InstAddrWidth-1:0] inst_addr_t;
    typedef logic [InstDataWidth-1:0] inst_data_t;

    localparam inst_data_t ZeroWord = '0;
    localparam inst_data_t NopInst  = ZeroWord;

    localparam logic [0:0] FetchIdle = 1'b0;
    localparam logic [0:0] FetchFill = 1'b1;

    localparam int LineWordsDefault = 4;

endpackage

// File: rtl/inst_fetch_buffer_line_store.sv
// rtl/inst_fetch_buffer_line_store.sv - one instruction line: single write port, async clear, comb read
module fetch_line_store
    import inst_fetch_buffer_pkg::*;
#(
    parameter int LINE_WORDS = LineWordsDefault,
    parameter int OFF_W      = $clog2(LINE_WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we_i,
    input  logic [OFF_W-1:0] waddr_i,
    input  inst_data_t       wdata_i,
    input  logic [OFF_W-1:0] raddr_i,
    output inst_data_t       rdata_o
);

    inst_data_t line_q [LINE_WORDS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LINE_WORDS; i++) begin
                line_q[i] <= ZeroWord;
            end
        end else if (we_i) begin
            line_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = line_q[raddr_i];

endmodule

// File: rtl/inst_fetch_buffer.sv
// rtl/inst_fetch_buffer.sv - single-line instruction buffer bridging the core ROM port to a req/ack memory
module inst_fetch_buffer
    import inst_fetch_buffer_pkg::*;
#(
    parameter int LINE_WORDS = LineWordsDefault
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rom_ce_i,
    input  logic [31:0] rom_addr_i,
    output logic [31:0] rom_data_o,
    output logic        stallreq_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int TAG_W = InstAddrWidth - 2 - OFF_W;

    logic [0:0]       state_q, state_d;
    logic             line_valid_q, line_valid_d;
    logic [TAG_W-1:0] line_tag_q, line_tag_d;
    logic [TAG_W-1:0] fill_tag_q, fill_tag_d;
    logic [OFF_W-1:0] fill_cnt_q, fill_cnt_d;

    logic [TAG_W-1:0] tag;
    logic [OFF_W-1:0] off;
    logic             hit;
    logic             miss;
    logic             in_fill;
    logic             fill_we;
    logic             last_word;
    inst_data_t       line_rdata;

    assign tag       = rom_addr_i[InstAddrWidth-1:2+OFF_W];
    assign off       = rom_addr_i[1+OFF_W:2];
    assign in_fill   = (state_q == FetchFill);
    assign hit       = rom_ce_i & line_valid_q & (tag == line_tag_q) & (state_q == FetchIdle);
    assign miss      = rom_ce_i & ~hit;
    assign fill_we   = in_fill & mem_ack_i;
    assign last_word = &fill_cnt_q;

    // Outputs are combinational so a hit costs no cycle; reset masks the stall immediately.
    assign rom_data_o = hit ? line_rdata : NopInst;
    assign stallreq_o = miss & ~rst;
    assign mem_req_o  = in_fill;
    assign mem_addr_o = in_fill ? {fill_tag_q, fill_cnt_q, 2'b00} : ZeroWord;

    always_comb begin
        state_d      = state_q;
        line_valid_d = line_valid_q;
        line_tag_d   = line_tag_q;
        fill_tag_d   = fill_tag_q;
        fill_cnt_d   = fill_cnt_q;
        case (state_q)
            FetchIdle: begin
                if (miss) begin
                    fill_tag_d   = tag;
                    fill_cnt_d   = '0;
                    line_valid_d = 1'b0;
                    state_d      = FetchFill;
                end
            end
            FetchFill: begin
                // The fill always runs to completion on the latched tag, whatever the core does.
                if (mem_ack_i) begin
                    fill_cnt_d = fill_cnt_q + OFF_W'(1);
                    if (last_word) begin
                        line_tag_d   = fill_tag_q;
                        line_valid_d = 1'b1;
                        fill_cnt_d   = '0;
                        state_d      = FetchIdle;
                    end
                end
            end
            default: state_d = FetchIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= FetchIdle;
            line_valid_q <= 1'b0;
            line_tag_q   <= '0;
            fill_tag_q   <= '0;
            fill_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            line_valid_q <= line_valid_d;
            line_tag_q   <= line_tag_d;
            fill_tag_q   <= fill_tag_d;
            fill_cnt_q   <= fill_cnt_d;
        end
    end

    fetch_line_store #(
        .LINE_WORDS (LINE_WORDS),
        .OFF_W      (OFF_W)
    ) u_line_store (
        .clk     (clk),
        .rst     (rst),
        .we_i    (fill_we),
        .waddr_i (fill_cnt_q),
        .wdata_i (mem_rdata_i),
        .raddr_i (off),
        .rdata_o (line_rdata)
    );

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// tb/tb_inst_fetch_buffer.sv - directed self-checking bench for inst_fetch_buffer
module tb_inst_fetch_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        rom_ce_i;
    logic [31:0] rom_addr_i;
    logic [31:0] rom_data_o;
    logic        stallreq_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    int errors = 0;
    int checks = 0;
    int ack_delay = 0;
    int wait_cnt = 0;
    bit force_ack = 1'b0;
    logic [31:0] ack_log[$];
    logic [31:0] req_trace[$];

    always #5 clk = ~clk;

    inst_fetch_buffer #(.LINE_WORDS(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .rom_ce_i    (rom_ce_i),
        .rom_addr_i  (rom_addr_i),
        .rom_data_o  (rom_data_o),
        .stallreq_o  (stallreq_o),
        .mem_req_o   (mem_req_o),
        .mem_addr_o  (mem_addr_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] idx;
        idx = {24'd0, a[9:2]};
        return 32'h3400_0000 + ((idx + 32'd1) << 16) + ((idx + 32'd2) << 4) + {a[31:10], 10'd0};
    endfunction

    // Memory model: acks after ack_delay idle cycles, logs every requested and acked address.
    initial begin
        mem_ack_i   = 1'b0;
        mem_rdata_i = 32'h0;
        forever begin
            @(negedge clk);
            #1;
            if (mem_req_o) begin
                req_trace.push_back(mem_addr_o);
                if (wait_cnt >= ack_delay) begin
                    mem_ack_i   = 1'b1;
                    mem_rdata_i = mem_word(mem_addr_o);
                    ack_log.push_back(mem_addr_o);
                    wait_cnt    = 0;
                end else begin
                    mem_ack_i   = 1'b0;
                    mem_rdata_i = 32'hBAD0_0000;
                    wait_cnt++;
                end
            end else begin
                wait_cnt    = 0;
                mem_ack_i   = force_ack;
                mem_rdata_i = 32'hDEAD_BEEF;
            end
        end
    end

    task automatic run_until_hit(input int budget, output int stalls, output bit timeout);
        stalls  = 0;
        timeout = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (!stallreq_o) begin
                timeout = 1'b0;
                break;
            end
            stalls++;
            @(negedge clk);
            #2;
        end
    endtask

    task automatic wait_acks(input int n);
        int k = 0;
        while (ack_log.size() < n && k < 50) begin
            @(negedge clk);
            #2;
            k++;
        end
        checks++;
        if (ack_log.size() < n) begin
            errors++;
            $display("FAIL wait_acks: got %0d acks, required %0d", ack_log.size(), n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rom_ce_i = 1'b0; rom_addr_i = 32'h0;
        repeat (2) @(negedge clk);
        #2;
        checks++; if (rom_data_o !== 32'h0) begin errors++; $display("FAIL reset_rom_data: got %h required 0", rom_data_o); end
        checks++; if (stallreq_o !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b required 0", stallreq_o); end
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b required 0", mem_req_o); end
        checks++; if (mem_addr_o !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h required 0", mem_addr_o); end
        rom_ce_i = 1'b1;
        #1;
        checks++; if (stallreq_o !== 1'b0) begin errors++; $display("FAIL reset_stall_ce: got %b required 0", stallreq_o); end
        rom_ce_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_first_fill();
        logic [31:0] exp_addr [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
        int stalls; bit to;
        ack_delay = 0; ack_log.delete();
        @(negedge clk);
        rom_ce_i = 1'b1; rom_addr_i = 32'h0;
        #2;
        run_until_hit(40, stalls, to);
        checks++; if (to) begin errors++; $display("FAIL first_fill_timeout: stall still %b, required 0", stallreq_o); end
        checks++; if (stalls != 5) begin errors++; $display("FAIL first_fill_stalls: got %0d required 5", stalls); end
        checks++; if (ack_log.size() != 4) begin errors++; $display("FAIL first_fill_acks: got %0d required 4", ack_log.size()); end
        for (int i = 0; i < 4 && i < ack_log.size(); i++) begin
            checks++;
            if (ack_log[i] !== exp_addr[i]) begin errors++; $display("FAIL first_fill_addr%0d: got %h required %h", i, ack_log[i], exp_addr[i]); end
        end
        checks++; if (rom_data_o !== 32'h3401_0020) begin errors++; $display("FAIL first_fill_data: got %h required 34010020", rom_data_o); end
    endtask

    task automatic test_hit_stream();
        logic [31:0] exp_data [4] = '{32'h3401_0020, 32'h3402_0030, 32'h3403_0040, 32'h3404_0050};
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            rom_addr_i = 32'(i * 4);
            #2;
            checks++; if (rom_data_o !== exp_data[i]) begin errors++; $display("FAIL hit_data%0d: got %h required %h", i, rom_data_o, exp_data[i]); end
            checks++; if (stallreq_o !== 1'b0 || mem_req_o !== 1'b0) begin errors++; $display("FAIL hit_quiet%0d: got stall=%b req=%b required 0/0", i, stallreq_o, mem_req_o); end
        end
    endtask

    task automatic test_slow_fill();
        int stalls; bit to;
        ack_delay = 3; req_trace.delete();
        @(negedge clk);
        rom_addr_i = 32'h10;
        #2;
        run_until_hit(100, stalls, to);
        checks++; if (to || stalls != 17) begin errors++; $display("FAIL slow_fill_stalls: got %0d (timeout=%b) required 17", stalls, to); end
        checks++; if (req_trace.size() != 16) begin errors++; $display("FAIL slow_fill_req_cycles: got %0d required 16", req_trace.size()); end
        if (req_trace.size() == 16) begin
            checks++;
            if (req_trace[0] !== 32'h10 || req_trace[3] !== 32'h10 || req_trace[4] !== 32'h14 || req_trace[15] !== 32'h1C) begin
                errors++;
                $display("FAIL slow_fill_hold: got %h %h %h %h required 10 10 14 1c", req_trace[0], req_trace[3], req_trace[4], req_trace[15]);
            end
        end
        checks++; if (rom_data_o !== 32'h3405_0060) begin errors++; $display("FAIL slow_fill_data: got %h required 34050060", rom_data_o); end
        ack_delay = 0;
    endtask

    task automatic test_redirect();
        logic [31:0] exp_addr [8] = '{32'h20, 32'h24, 32'h28, 32'h2C, 32'h40, 32'h44, 32'h48, 32'h4C};
        int stalls; bit to;
        ack_log.delete();
        @(negedge clk);
        rom_addr_i = 32'h20;
        #2;
        wait_acks(2);
        @(negedge clk);
        rom_addr_i = 32'h40;
        #2;
        run_until_hit(60, stalls, to);
        checks++; if (to) begin errors++; $display("FAIL redirect_timeout: stall still %b required 0", stallreq_o); end
        checks++; if (ack_log.size() != 8) begin errors++; $display("FAIL redirect_acks: got %0d required 8", ack_log.size()); end
        for (int i = 0; i < 8 && i < ack_log.size(); i++) begin
            checks++;
            if (ack_log[i] !== exp_addr[i]) begin errors++; $display("FAIL redirect_addr%0d: got %h required %h", i, ack_log[i], exp_addr[i]); end
        end
        checks++; if (rom_data_o !== 32'h3411_0120) begin errors++; $display("FAIL redirect_data: got %h required 34110120", rom_data_o); end
    endtask

    task automatic test_async_reset();
        int stalls; bit to;
        ack_log.delete();
        @(negedge clk);
        rom_addr_i = 32'h0;
        #2;
        wait_acks(1);
        checks++; if (mem_req_o !== 1'b1) begin errors++; $display("FAIL areset_pre_req: got %b required 1", mem_req_o); end
        #1 rst = 1'b1;
        #1;
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL areset_req: got %b required 0", mem_req_o); end
        checks++; if (stallreq_o !== 1'b0) begin errors++; $display("FAIL areset_stall: got %b required 0", stallreq_o); end
        checks++; if (rom_data_o !== 32'h0) begin errors++; $display("FAIL areset_data: got %h required 0", rom_data_o); end
        @(negedge clk);
        #3 rst = 1'b0; rom_ce_i = 1'b0;
        ack_log.delete();
        @(negedge clk);
        rom_ce_i = 1'b1;
        #2;
        run_until_hit(40, stalls, to);
        checks++; if (to || stalls != 5) begin errors++; $display("FAIL areset_refill_stalls: got %0d (timeout=%b) required 5", stalls, to); end
        checks++; if (ack_log.size() != 4 || ack_log[0] !== 32'h0) begin errors++; $display("FAIL areset_refill_acks: got %0d acks required 4 from 0", ack_log.size()); end
        checks++; if (rom_data_o !== 32'h3401_0020) begin errors++; $display("FAIL areset_refill_data: got %h required 34010020", rom_data_o); end
    endtask

    task automatic test_ce_off();
        logic [31:0] addrs [3] = '{32'h40, 32'h4, 32'hFFFF_FFFC};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rom_ce_i = 1'b0; rom_addr_i = addrs[i];
            #2;
            checks++;
            if (rom_data_o !== 32'h0 || stallreq_o !== 1'b0 || mem_req_o !== 1'b0) begin
                errors++;
                $display("FAIL ce_off%0d: got data=%h stall=%b req=%b required 0/0/0", i, rom_data_o, stallreq_o, mem_req_o);
            end
        end
        @(negedge clk);
        rom_ce_i = 1'b1; rom_addr_i = 32'h4;
        #2;
        checks++; if (stallreq_o !== 1'b0 || rom_data_o !== 32'h3402_0030) begin errors++; $display("FAIL ce_off_kept: got stall=%b data=%h required 0/34020030", stallreq_o, rom_data_o); end
    endtask

    task automatic test_idle_ack();
        @(negedge clk);
        rom_ce_i = 1'b0; force_ack = 1'b1;
        repeat (3) @(negedge clk);
        force_ack = 1'b0;
        @(negedge clk);
        rom_ce_i = 1'b1; rom_addr_i = 32'h8;
        #2;
        checks++; if (stallreq_o !== 1'b0 || rom_data_o !== 32'h3403_0040) begin errors++; $display("FAIL idle_ack: got stall=%b data=%h required 0/34030040", stallreq_o, rom_data_o); end
    endtask

    task automatic test_ce_drop();
        int k = 0;
        ack_log.delete();
        @(negedge clk);
        rom_addr_i = 32'h100;
        #2;
        wait_acks(1);
        @(negedge clk);
        rom_ce_i = 1'b0;
        #2;
        checks++; if (stallreq_o !== 1'b0) begin errors++; $display("FAIL ce_drop_stall: got %b required 0", stallreq_o); end
        while (mem_req_o && k < 20) begin @(negedge clk); #2; k++; end
        checks++; if (ack_log.size() != 4) begin errors++; $display("FAIL ce_drop_acks: got %0d required 4", ack_log.size()); end
        @(negedge clk);
        rom_ce_i = 1'b1; rom_addr_i = 32'h104;
        #2;
        checks++; if (stallreq_o !== 1'b0 || rom_data_o !== 32'h3442_0430) begin errors++; $display("FAIL ce_drop_hit: got stall=%b data=%h required 0/34420430", stallreq_o, rom_data_o); end
    endtask

    task automatic test_top_addr();
        int stalls; bit to;
        ack_log.delete();
        @(negedge clk);
        rom_addr_i = 32'hFFFF_FFFC;
        #2;
        run_until_hit(40, stalls, to);
        checks++; if (to || stalls != 5) begin errors++; $display("FAIL top_stalls: got %0d (timeout=%b) required 5", stalls, to); end
        checks++;
        if (ack_log.size() != 4 || ack_log[0] !== 32'hFFFF_FFF0 || ack_log[3] !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL top_addrs: got %0d acks required fff0..fffc", ack_log.size());
        end
        checks++; if (rom_data_o !== 32'h3500_0C10) begin errors++; $display("FAIL top_data: got %h required 35000c10", rom_data_o); end
        @(negedge clk);
        rom_addr_i = 32'hFFFF_FFF0;
        #2;
        checks++; if (stallreq_o !== 1'b0 || rom_data_o !== 32'h34FD_0BE0) begin errors++; $display("FAIL top_word0: got stall=%b data=%h required 0/34fd0be0", stallreq_o, rom_data_o); end
        @(negedge clk);
        rom_addr_i = 32'h0;
        #2;
        checks++; if (stallreq_o !== 1'b1) begin errors++; $display("FAIL top_tag_miss: got %b required 1", stallreq_o); end
        rom_ce_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_fill();
        test_hit_stream();
        test_slow_fill();
        test_redirect();
        test_async_reset();
        test_ce_off();
        test_idle_ack();
        test_ce_drop();
        test_top_addr();
        repeat (6) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
